alu_uart_ctrl: RTL and testbench

Byte-stream command sequencer for the 8-operation ALU. It collects operand A, operand B and an opcode from a UART receiver, drives the combinational ALU, and registers the result and flags. It then returns a two-byte response (result, then flags) through a UART transmitter. It sits between the uart_rx/uart_tx pair and the ALU in the top level and is the only block that drives the ALU inputs.

---
 rtl/alu_uart_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_alu_uart_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl.sv
// ============================================================================
//  Module   : alu_uart_ctrl
//  Purpose  : Byte-stream command sequencer for an 8-operation ALU. Collects
//             operand A, operand B and an opcode from a UART receiver, drives
//             the ALU, captures result and flags, then returns a two-byte
//             response (result, then flags) through a UART transmitter.
//  Ports    :
//    i_clk        system clock, rising edge
//    i_rst_n      asynchronous active-low reset
//    i_rx_data    received byte
//    i_rx_valid   one-cycle pulse: i_rx_data valid
//    o_tx_data    byte to transmit (holds last value outside send states)
//    o_tx_start   one-cycle pulse: start transmitting o_tx_data
//    i_tx_done    one-cycle pulse: transmitter finished current byte
//    o_alu_a      ALU operand A
//    o_alu_b      ALU operand B
//    o_alu_op     ALU opcode
//    i_alu_res    ALU result
//    i_alu_carry  ALU carry
//    o_busy       high from opcode acceptance until the flags byte is sent
//    o_timeout    one-cycle pulse: partial frame aborted
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_A   = 4'd0,
    WAIT_B   = 4'd1,
    WAIT_OP  = 4'd2,
    EXEC     = 4'd3,
    SEND_RES = 4'd4,
    WAIT_RES = 4'd5,
    SEND_FLG = 4'd6,
    WAIT_FLG = 4'd7
  } state_t;

  state_t             state;
  logic [NB_DATA-1:0] res_q;
  logic [NB_DATA-1:0] flg_q;
  logic [CNT_W-1:0]   cnt;
  logic               invalid_q;

  logic [CNT_W-1:0]   cnt_next;
  logic               expire;
  logic               op_ok;
  logic               res_zero;

  // Opcode byte is matched over its full width, so e.g. 0x60 does not alias 0x20.
  always_comb begin
    op_ok = 1'b0;
    case (i_rx_data)
      NB_DATA'(8'h20), NB_DATA'(8'h22), NB_DATA'(8'h24), NB_DATA'(8'h25),
      NB_DATA'(8'h26), NB_DATA'(8'h03), NB_DATA'(8'h02), NB_DATA'(8'h27):
        op_ok = 1'b1;
      default:
        op_ok = 1'b0;
    endcase
  end

  // The counter is 0 in the first waiting cycle after a byte; the frame is
  // abandoned in the cycle where the count would reach TIMEOUT_CYCLES-1, so
  // o_timeout appears TIMEOUT_CYCLES cycles after the last accepted byte.
  // A byte arriving in that very cycle takes priority.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    expire   = ((state == WAIT_B) || (state == WAIT_OP)) &&
               !i_rx_valid && (cnt_next == CNT_LAST);
    res_zero = (i_alu_res == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      res_q      <= '0;
      flg_q      <= '0;
      cnt        <= '0;
      invalid_q  <= 1'b0;
    end else begin
      // Pulses and the counter fall back to idle unless a state overrides.
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      cnt        <= '0;

      case (state)
        WAIT_A: begin
          if (i_rx_valid) begin
            o_alu_a <= i_rx_data;
            state   <= WAIT_B;
          end
        end

        WAIT_B: begin
          if (i_rx_valid) begin
            o_alu_b <= i_rx_data;
            state   <= WAIT_OP;
          end else if (expire) begin
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end else begin
            cnt <= cnt_next;
          end
        end

        WAIT_OP: begin
          if (i_rx_valid) begin
            if (op_ok) begin
              o_alu_op  <= i_rx_data[NB_OP-1:0];
              invalid_q <= 1'b0;
            end else begin
              invalid_q <= 1'b1;
            end
            o_busy <= 1'b1;
            state  <= EXEC;
          end else if (expire) begin
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end else begin
            cnt <= cnt_next;
          end
        end

        // Result is loaded straight into o_tx_data here so the start pulse
        // in SEND_RES already carries it.
        EXEC: begin
          if (invalid_q) begin
            res_q     <= '0;
            flg_q     <= {1'b1, {(NB_DATA-1){1'b0}}};
            o_tx_data <= '0;
          end else begin
            res_q     <= i_alu_res;
            flg_q     <= {1'b0, {(NB_DATA-3){1'b0}}, res_zero, i_alu_carry};
            o_tx_data <= i_alu_res;
          end
          o_tx_start <= 1'b1;
          state      <= SEND_RES;
        end

        SEND_RES: begin
          o_tx_data <= res_q;
          state     <= WAIT_RES;
        end

        WAIT_RES: begin
          if (i_tx_done) begin
            o_tx_data  <= flg_q;
            o_tx_start <= 1'b1;
            state      <= SEND_FLG;
          end
        end

        SEND_FLG: begin
          state <= WAIT_FLG;
        end

        WAIT_FLG: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= WAIT_A;
          end
        end

        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_uart_ctrl.sv
// ============================================================================
//  Module   : tb_alu_uart_ctrl
//  Purpose  : Self-checking bench for alu_uart_ctrl. A stand-in ALU answers
//             the DUT's operand/opcode outputs; a frame-level reference model
//             predicts operand registers, response bytes, busy and pulse
//             counts. Directed steps first, then randomized frames.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_uart_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_valid;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_carry;
  logic               busy;
  logic               timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_seen  = 0;
  int to_seen  = 0;
  int exp_tx   = 0;
  int exp_to   = 0;
  logic [NB_OP-1:0] exp_op = '0;

  always #5 clk = ~clk;

  alu_uart_ctrl #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_done(tx_done),
    .o_alu_a(alu_a),
    .o_alu_b(alu_b),
    .o_alu_op(alu_op),
    .i_alu_res(alu_res),
    .i_alu_carry(alu_carry),
    .o_busy(busy),
    .o_timeout(timeout)
  );

  // Stand-in ALU: carry is reported as the borrow of SUB, 0 for other ops.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] op);
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      8'h20: r = a + b;
      8'h22: begin r = a - b; c = (a < b); end
      8'h24: r = a & b;
      8'h25: r = a | b;
      8'h26: r = a ^ b;
      8'h03: r = 8'($signed(a) >>> b[2:0]);
      8'h02: r = a >> b[2:0];
      8'h27: r = ~(a | b);
      default: r = 8'h00;
    endcase
    return {c, r};
  endfunction

  assign {alu_carry, alu_res} = alu_fn(alu_a, alu_b, {2'b00, alu_op});

  function automatic bit is_valid(input logic [7:0] op);
    logic [7:0] ops [8];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Pulse counters sample the value present just before each rising edge.
  always @(posedge clk) begin
    if (tx_start) tx_seen++;
    if (timeout)  to_seen++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int g1, input int g2, input bit early_done,
                           input bit drop, input bit do_reset,
                           output logic [7:0] got_res, output logic [7:0] got_flg);
    logic [8:0] r;
    logic [7:0] er, ef;
    bit         v;
    got_flg = 8'h00;
    send_byte(a);
    check("alu_a", alu_a, a);
    repeat (g1) tick();
    send_byte(b);
    check("alu_b", alu_b, b);
    repeat (g2) tick();
    send_byte(op);
    v = is_valid(op);
    if (v) exp_op = op[5:0];
    r  = alu_fn(a, b, op);
    er = v ? r[7:0] : 8'h00;
    ef = v ? {6'b0, (r[7:0] == 8'h00), r[8]} : 8'h80;
    // EXEC cycle
    check("busy_exec", busy, 1'b1);
    check("alu_op", alu_op, exp_op);
    check("start_exec", tx_start, 1'b0);
    tick();
    // SEND_RES cycle: two cycles after the opcode pulse
    got_res = tx_data;
    check("start_res", tx_start, 1'b1);
    check("res_byte", tx_data, er);
    if (early_done) tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("start_once_res", tx_start, 1'b0);
    check("busy_wait_res", busy, 1'b1);
    if (drop) begin
      send_byte(8'h11);
      send_byte(8'h22);
    end
    if (do_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      exp_op = '0;
      exp_tx += 1;
      tick();
      rst_n   = 1'b1;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (4) tick();
      check("busy_after_rst", busy, 1'b0);
      check("tx_count_rst", tx_seen, exp_tx);
    end else begin
      repeat ($urandom_range(0, 3)) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      got_flg = tx_data;
      check("start_flg", tx_start, 1'b1);
      check("flg_byte", tx_data, ef);
      check("busy_flg", busy, 1'b1);
      tick();
      check("start_once_flg", tx_start, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("busy_idle", busy, 1'b0);
      check("hold_a", alu_a, a);
      check("hold_b", alu_b, b);
      exp_tx += 2;
      check("tx_count", tx_seen, exp_tx);
    end
  endtask

  initial begin
    logic [7:0] res, flg, a, b, op;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    repeat (3) tick();
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_busy", busy, 0);
    check("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();

    // Subtraction with borrow
    run_frame(8'h05, 8'h07, 8'h22, 0, 0, 0, 0, 0, res, flg);
    check("sub_res", res, 8'hFE);
    check("sub_flg", flg, 8'h01);

    // Zero result
    run_frame(8'hFF, 8'h01, 8'h20, 2, 1, 0, 0, 0, res, flg);
    check("zero_res", res, 8'h00);
    check("zero_flg", flg, 8'h02);

    // Invalid opcode keeps the previous opcode
    run_frame(8'h10, 8'h20, 8'h3F, 0, 3, 0, 0, 0, res, flg);
    check("inv_res", res, 8'h00);
    check("inv_flg", flg, 8'h80);
    check("inv_op_kept", alu_op, 8'h20);

    // Timeout after operand A
    send_byte(8'hAA);
    repeat (TO - 2) tick();
    check("to_not_yet", timeout, 1'b0);
    tick();
    check("to_pulse", timeout, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_keep_a", alu_a, 8'hAA);
    check("to_keep_b", alu_b, 8'h20);
    exp_to++;
    tick();
    check("to_once", timeout, 1'b0);
    run_frame(8'h03, 8'h04, 8'h25, 0, 0, 0, 0, 0, res, flg);
    check("after_to_res", res, 8'h07);
    check("to_count", to_seen, exp_to);

    // Bytes arriving exactly in the expiry cycle win
    run_frame(8'h4C, 8'h0C, 8'h24, TO - 2, TO - 2, 0, 0, 0, res, flg);
    check("edge_res", res, 8'h0C);
    check("edge_to_count", to_seen, exp_to);

    // Bytes and early tx_done while busy are ignored
    run_frame(8'h09, 8'h01, 8'h26, 1, 1, 1, 1, 0, res, flg);
    run_frame(8'h02, 8'h03, 8'h20, 0, 0, 0, 0, 0, res, flg);
    check("drop_res", res, 8'h05);
    check("drop_flg", flg, 8'h00);

    // Reset while waiting for the result byte to finish
    run_frame(8'h30, 8'h12, 8'h20, 0, 0, 0, 0, 1, res, flg);
    run_frame(8'h81, 8'h02, 8'h03, 0, 0, 0, 0, 0, res, flg);
    check("post_rst_res", res, 8'hE0);
    check("post_rst_flg", flg, 8'h00);

    // Randomized frames
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ops [8];
      int idx;
      ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
      a   = 8'($urandom);
      b   = 8'($urandom);
      idx = $urandom_range(0, 8);
      if (idx < 8) begin
        op = ops[idx];
      end else begin
        op = 8'($urandom);
        while (is_valid(op)) op = 8'($urandom);
      end
      run_frame(a, b, op, $urandom_range(0, TO - 2), $urandom_range(0, TO - 2),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, res, flg);
    end

    check("final_to_count", to_seen, exp_to);
    check("final_tx_count", tx_seen, exp_tx);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
